// File: rtl/pheap_level_stage.sv
// pheap_level_stage: one level of a pipelined P-heap.
// Holds the entry registers of its level and serves INSERT/REMOVE tokens from
// the level above. It reads the two child entries through the lower level's
// pair-read port, rewrites its own entry and passes a token further down.
// Optional build macro: PHEAP_MIN_ORDER_EN selects min-heap ordering
// (smaller value wins); without it the stage orders as a max-heap.
module pheap_level_stage #(
  parameter int W     = 32,
  parameter int LEVEL = 1,
  parameter int DEPTH = 4,
  localparam int PW   = (LEVEL > 0) ? LEVEL : 1,
  localparam int CW   = DEPTH - LEVEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [PW-1:0]     in_pos,
  input  logic [W-1:0]      in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_op,
  output logic [PW:0]       out_pos,
  output logic [W-1:0]      out_value,
  output logic              busy,
  input  logic              child_busy,
  output logic [PW-1:0]     c_pair,
  input  logic [W+CW-1:0]   c_left,
  input  logic [W+CW-1:0]   c_right,
  input  logic [PW-1:0]     p_pair,
  output logic [W+CW:0]     p_left,
  output logic [W+CW:0]     p_right
  ,
  output logic              rm_valid,
  output logic [W-1:0]      rm_value,
  output logic              err
);

  // The storage array always spans the full pos range. At the root only slot 0
  // is ever written; slot 1 stays at its reset value and exists so the pair
  // read port can return an empty right neighbour without special casing.
  localparam int NS = 2 ** PW;
  localparam bit LEAF = (LEVEL == DEPTH - 1);
  localparam logic [CW-1:0] CAPFULL = '1;
  localparam logic OP_INSERT = 1'b0;

  typedef enum logic [1:0] {IDLE, RD, UPD, FWD} state_t;

  state_t         state_q;
  logic           op_q;
  logic [PW-1:0]  pos_q;
  logic [W-1:0]   val_q;

  logic           entAct_q [NS];
  logic [CW-1:0]  entCap_q [NS];
  logic [W-1:0]   entVal_q [NS];

  logic           curAct_q;
  logic [CW-1:0]  curCap_q;
  logic [W-1:0]   curVal_q;
  logic           cLAct_q, cRAct_q, cLCapNz_q;
  logic [W-1:0]   cLVal_q, cRVal_q;

  logic           outOp_q;
  logic [PW:0]    outPos_q;
  logic [W-1:0]   outValue_q;
  logic           rmValid_q;
  logic [W-1:0]   rmValue_q;
  logic           err_q;

  logic           cLAct, cRAct, cLCapNz, childStall;
  logic [W-1:0]   cLVal, cRVal;
  logic [PW-1:0]  slot, pairL, pairR;

  logic           wrAct_d;
  logic [CW-1:0]  wrCap_d, capDec, capInc;
  logic [W-1:0]   wrVal_d, fwdVal_d;
  logic           fwd_d, fwdSel_d, rm_d, illegal_d;

  // True when value a displaces value b under the configured ordering.
  function automatic logic beats(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef PHEAP_MIN_ORDER_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  // A leaf has no level below: its children look empty and full, and the
  // child busy handshake never stalls it.
  if (LEAF) begin : g_leaf
    logic unusedLeafInputs;
    assign unusedLeafInputs = ^{c_left, c_right, child_busy};
    assign cLAct      = 1'b0;
    assign cRAct      = 1'b0;
    assign cLCapNz    = 1'b0;
    assign cLVal      = '0;
    assign cRVal      = '0;
    assign childStall = 1'b0;
  end else begin : g_inner
    assign cLAct      = c_left[W+CW-1];
    assign cRAct      = c_right[W+CW-1];
    assign cLCapNz    = |c_left[W+CW-2:W];
    assign cLVal      = c_left[W-1:0];
    assign cRVal      = c_right[W-1:0];
    assign childStall = child_busy;
  end

  assign slot  = (LEVEL == 0) ? '0 : pos_q;
  assign pairL = (LEVEL == 0) ? '0 : PW'({p_pair, 1'b0});
  assign pairR = pairL | PW'(1);

  assign p_left    = {entAct_q[pairL], entCap_q[pairL], entVal_q[pairL]};
  assign p_right   = {entAct_q[pairR], entCap_q[pairR], entVal_q[pairR]};
  assign c_pair    = pos_q;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == FWD);
  assign out_op    = outOp_q;
  assign out_pos   = outPos_q;
  assign out_value = outValue_q;
  assign rm_valid  = rmValid_q;
  assign rm_value  = rmValue_q;
  assign err       = err_q;

  // Decide the entry rewrite and the downstream token from the snapshot taken in RD.
  always_comb begin
    wrAct_d   = curAct_q;
    wrCap_d   = curCap_q;
    wrVal_d   = curVal_q;
    fwd_d     = 1'b0;
    fwdSel_d  = 1'b0;
    fwdVal_d  = '0;
    rm_d      = 1'b0;
    illegal_d = 1'b0;
    capDec    = (curCap_q != '0) ? curCap_q - CW'(1) : curCap_q;
    capInc    = (curCap_q != CAPFULL) ? curCap_q + CW'(1) : curCap_q;
    if (op_q == OP_INSERT) begin
      if (!curAct_q) begin
        wrAct_d = 1'b1;
        wrCap_d = capDec;
        wrVal_d = val_q;
      end else if (curCap_q == '0 || LEAF) begin
        illegal_d = 1'b1;
      end else begin
        wrCap_d  = capDec;
        fwd_d    = 1'b1;
        fwdSel_d = cLCapNz_q ? 1'b0 : 1'b1;
        if (beats(val_q, curVal_q)) begin
          wrVal_d  = val_q;
          fwdVal_d = curVal_q;
        end else begin
          fwdVal_d = val_q;
        end
      end
    end else begin
      if (!curAct_q) begin
        illegal_d = 1'b1;
      end else begin
        rm_d    = 1'b1;
        wrCap_d = capInc;
        if (!cLAct_q && !cRAct_q) begin
          wrAct_d = 1'b0;
        end else begin
          fwd_d = 1'b1;
          if (cLAct_q && cRAct_q) begin
            fwdSel_d = beats(cRVal_q, cLVal_q);
          end else begin
            fwdSel_d = cRAct_q;
          end
          wrVal_d = fwdSel_d ? cRVal_q : cLVal_q;
        end
      end
    end
  end

  // Token FSM, entry storage and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      pos_q      <= '0;
      val_q      <= '0;
      curAct_q   <= 1'b0;
      curCap_q   <= '0;
      curVal_q   <= '0;
      cLAct_q    <= 1'b0;
      cRAct_q    <= 1'b0;
      cLCapNz_q  <= 1'b0;
      cLVal_q    <= '0;
      cRVal_q    <= '0;
      outOp_q    <= 1'b0;
      outPos_q   <= '0;
      outValue_q <= '0;
      rmValid_q  <= 1'b0;
      rmValue_q  <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        entAct_q[i] <= 1'b0;
        entCap_q[i] <= CAPFULL;
        entVal_q[i] <= '0;
      end
    end else begin
      rmValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            pos_q   <= in_pos;
            val_q   <= in_value;
            state_q <= RD;
          end
        end
        RD: begin
          if (!childStall) begin
            curAct_q  <= entAct_q[slot];
            curCap_q  <= entCap_q[slot];
            curVal_q  <= entVal_q[slot];
            cLAct_q   <= cLAct;
            cRAct_q   <= cRAct;
            cLCapNz_q <= cLCapNz;
            cLVal_q   <= cLVal;
            cRVal_q   <= cRVal;
            state_q   <= UPD;
          end
        end
        UPD: begin
          entAct_q[slot] <= wrAct_d;
          entCap_q[slot] <= wrCap_d;
          entVal_q[slot] <= wrVal_d;
          if (rm_d) begin
            rmValid_q <= 1'b1;
            rmValue_q <= curVal_q;
          end
          if (illegal_d) begin
            err_q <= 1'b1;
          end
          if (fwd_d) begin
            outOp_q    <= op_q;
            outPos_q   <= {pos_q, fwdSel_d};
            outValue_q <= fwdVal_d;
            state_q    <= FWD;
          end else begin
            state_q <= IDLE;
          end
        end
        FWD: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
